// File: rtl/mem_stage_lsu_pkg.sv
// Shared RISC-V LSU definitions: funct3 access codes, LSU state encoding,
// and the byte-enable helper used by the MEM stage.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // funct3[1:0] encodes the access size for both signed and unsigned forms.
  function automatic logic [3:0] lsu_byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack bus between the MEM-stage LSU (master) and data memory (slave).
interface mem_stage_lsu_if #(parameter int XLEN = 32);

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );

endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational load formatter: picks the byte/halfword lane of a raw memory
// word and sign- or zero-extends it to XLEN.
module lsu_load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_word,
  input  logic [1:0]      i_offset,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_result = i_word;
    case (i_funct3)
      F3_B:    o_result = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_H:    o_result = {{(XLEN-16){w_half[15]}}, w_half};
      F3_BU:   o_result = {{(XLEN-8){1'b0}}, w_byte};
      F3_HU:   o_result = {{(XLEN-16){1'b0}}, w_half};
      default: o_result = i_word;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: IDLE/BUSY/DONE handshake to data memory with
// alignment checks. Optional BUSY timeout enabled by defining LSU_TIMEOUT_EN.
module mem_stage_lsu
  import riscv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read_in,
  input  logic                 mem_write_in,
  input  logic [2:0]           funct3_in,
  input  logic [XLEN-1:0]      address_in,
  input  logic [XLEN-1:0]      write_data_in,
  mem_stage_lsu_if.master      bus,
  output logic [XLEN-1:0]      read_data_out,
  output logic                 stall_out,
  output logic                 fault_out
);

  lsu_state_t      r_state;
  logic [2:0]      r_funct3;
  logic [1:0]      r_offset;
  logic            w_access;
  logic            w_illegal;
  logic            w_misalign;
  logic            w_fault;
  logic            w_start;
  logic [XLEN-1:0] w_store_data;
  logic [XLEN-1:0] w_load_data;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] r_cnt;
`endif

  assign w_access = mem_read_in | mem_write_in;

  // Unsigned forms exist only for loads; anything unlisted is illegal.
  always_comb begin
    w_illegal  = mem_read_in & mem_write_in;
    w_misalign = 1'b0;
    case (funct3_in)
      F3_B:  w_misalign = 1'b0;
      F3_H:  w_misalign = address_in[0];
      F3_W:  w_misalign = |address_in[1:0];
      F3_BU: w_illegal  = w_illegal | mem_write_in;
      F3_HU: begin
        w_illegal  = w_illegal | mem_write_in;
        w_misalign = address_in[0];
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_fault   = w_access & (w_illegal | w_misalign);
  assign w_start   = (r_state == IDLE) & w_access & ~w_fault;
  assign stall_out = w_start | (r_state == BUSY);

  always_comb begin
    case (funct3_in[1:0])
      2'b00:   w_store_data = {4{write_data_in[7:0]}};
      2'b01:   w_store_data = {2{write_data_in[15:0]}};
      default: w_store_data = write_data_in;
    endcase
  end

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .i_word   (bus.dmem_rdata),
    .i_offset (r_offset),
    .i_funct3 (r_funct3),
    .o_result (w_load_data)
  );

  // Bus outputs are latched on entry to BUSY and held until the ack edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_funct3       <= 3'b000;
      r_offset       <= 2'b00;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_be    <= 4'b0000;
      bus.dmem_wdata <= '0;
      read_data_out  <= '0;
      fault_out      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_cnt          <= '0;
`endif
    end else begin
      fault_out <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            bus.dmem_req   <= 1'b1;
            bus.dmem_we    <= mem_write_in;
            bus.dmem_addr  <= {address_in[XLEN-1:2], 2'b00};
            bus.dmem_be    <= lsu_byte_en(funct3_in, address_in[1:0]);
            bus.dmem_wdata <= w_store_data;
            r_funct3       <= funct3_in;
            r_offset       <= address_in[1:0];
            r_state        <= BUSY;
`ifdef LSU_TIMEOUT_EN
            r_cnt          <= '0;
`endif
          end else if (w_fault) begin
            fault_out <= 1'b1;
          end
        end
        BUSY: begin
          if (bus.dmem_ack) begin
            bus.dmem_req <= 1'b0;
            if (!bus.dmem_we) read_data_out <= w_load_data;
            r_state <= DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.dmem_req  <= 1'b0;
            fault_out     <= 1'b1;
            read_data_out <= '0;
            r_state       <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
